// File: rtl/arith_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_dec_pkg
//  Description : Shared constants for the arithmetic decoder control block:
//                state encoding, shift width, byte size and default sizing.
//  Revision    : 1.0  initial release
// ============================================================================
package arith_dec_pkg;

    localparam int C_SHIFT_W             = 4;
    localparam int C_BYTE_BITS           = 8;
    localparam int C_INIT_BYTES_DEF      = 2;
    localparam int C_REFILL_THRESH_DEF   = 16;
    localparam int C_AVAIL_W_DEF         = 6;

    localparam logic [2:0] C_ST_RST    = 3'd0;
    localparam logic [2:0] C_ST_INIT   = 3'd1;
    localparam logic [2:0] C_ST_IDLE   = 3'd2;
    localparam logic [2:0] C_ST_S1     = 3'd3;
    localparam logic [2:0] C_ST_S2     = 3'd4;
    localparam logic [2:0] C_ST_S3     = 3'd5;
    localparam logic [2:0] C_ST_REFILL = 3'd6;

    typedef enum logic [2:0] {
        ST_RST    = C_ST_RST,
        ST_INIT   = C_ST_INIT,
        ST_IDLE   = C_ST_IDLE,
        ST_S1     = C_ST_S1,
        ST_S2     = C_ST_S2,
        ST_S3     = C_ST_S3,
        ST_REFILL = C_ST_REFILL
    } state_t;

endpackage
`default_nettype wire

// File: rtl/arith_dec_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arith_dec_bit_counter
//  Description : Tracks the number of valid bits in the dif window. Adds a
//                byte on each load, subtracts the renormalization shift with
//                saturation at zero, and raises a sticky underflow flag.
//                Also reports whether the post-update count is below the
//                refill threshold so the FSM can pick its next state.
//  Revision    : 1.0  initial release
// ============================================================================
module arith_dec_bit_counter
    import arith_dec_pkg::*;
#(
    parameter int AVAIL_W       = C_AVAIL_W_DEF,
    parameter int REFILL_THRESH = C_REFILL_THRESH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_ctrl,
    input  logic                 load,
    input  logic                 sub,
    input  logic [C_SHIFT_W-1:0] shift,
    output logic [AVAIL_W-1:0]   bits_avail,
    output logic                 dec_err,
    output logic                 below_thresh
);

    logic [AVAIL_W-1:0] r_avail;
    logic               r_err;
    logic [AVAIL_W-1:0] w_shift_ext;
    logic [AVAIL_W-1:0] w_avail_nxt;
    logic               w_underflow;

    assign w_shift_ext = AVAIL_W'(shift);
    assign w_underflow = sub && (w_shift_ext > r_avail);

    // Next bit count: loads and the ST3 subtract never coincide
    always_comb begin
        w_avail_nxt = r_avail;
        if (load) begin
            w_avail_nxt = r_avail + AVAIL_W'(C_BYTE_BITS);
        end else if (sub) begin
            w_avail_nxt = w_underflow ? '0 : (r_avail - w_shift_ext);
        end
    end

    assign below_thresh = (w_avail_nxt < AVAIL_W'(REFILL_THRESH));

    // Bit count register and sticky underflow flag
    always_ff @(posedge clk or negedge reset_ctrl) begin
        if (!reset_ctrl) begin
            r_avail <= '0;
            r_err   <= 1'b0;
        end else begin
            r_avail <= w_avail_nxt;
            r_err   <= r_err | w_underflow;
        end
    end

    assign bits_avail = r_avail;
    assign dec_err    = r_err;

endmodule
`default_nettype wire

// File: rtl/arith_dec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arith_dec_ctrl
//  Description : Control FSM for the 3-stage arithmetic decoder pipeline
//                (CDF/range, symbol compare, renormalize). Issues one-hot
//                stage enables for one symbol at a time and keeps the dif
//                window topped up from the byte stream.
//                Optional feature macro: ARITH_DEC_STALL_CNT_EN adds a
//                saturating 16-bit stall_cnt output.
//  Revision    : 1.0  initial release
// ============================================================================
module arith_dec_ctrl
    import arith_dec_pkg::*;
#(
    parameter int INIT_BYTES    = C_INIT_BYTES_DEF,
    parameter int REFILL_THRESH = C_REFILL_THRESH_DEF,
    parameter int AVAIL_W       = C_AVAIL_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_ctrl,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    input  logic [C_SHIFT_W-1:0] renorm_shift,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic                 stream_end,
    output logic                 byte_load,
    output logic                 pad_load,
    output logic                 en_s1,
    output logic                 en_s2,
    output logic                 en_s3,
    output logic                 sym_done,
    output logic [AVAIL_W-1:0]   bits_avail,
    output logic                 dec_err
`ifdef ARITH_DEC_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int INIT_CNT_W = (INIT_BYTES < 2) ? 1 : $clog2(INIT_BYTES);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [INIT_CNT_W-1:0]  r_init_cnt;
    logic                   w_loading;
    logic                   w_load;
    logic                   w_sub;
    logic                   w_below;
    logic                   w_init_last;

    // Byte slot handling is shared by INIT and REFILL; a real byte beats padding
    assign w_loading   = (r_state == ST_INIT) || (r_state == ST_REFILL);
    assign byte_load   = w_loading && byte_valid;
    assign pad_load    = w_loading && !byte_valid && stream_end;
    assign w_load      = byte_load || pad_load;
    assign w_sub       = (r_state == ST_S3);
    assign w_init_last = (r_init_cnt == INIT_CNT_W'(INIT_BYTES - 1));

    arith_dec_bit_counter #(
        .AVAIL_W       (AVAIL_W),
        .REFILL_THRESH (REFILL_THRESH)
    ) u_bit_counter (
        .clk          (clk),
        .reset_ctrl   (reset_ctrl),
        .load         (w_load),
        .sub          (w_sub),
        .shift        (renorm_shift),
        .bits_avail   (bits_avail),
        .dec_err      (dec_err),
        .below_thresh (w_below)
    );

    // State register
    always_ff @(posedge clk or negedge reset_ctrl) begin
        if (!reset_ctrl) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        sym_ready   = 1'b0;
        byte_ready  = 1'b0;
        en_s1       = 1'b0;
        en_s2       = 1'b0;
        en_s3       = 1'b0;
        sym_done    = 1'b0;
        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_INIT;
            end
            ST_INIT: begin
                byte_ready = 1'b1;
                if (w_load && w_init_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    w_state_nxt = ST_S1;
                end
            end
            ST_S1: begin
                en_s1       = 1'b1;
                w_state_nxt = ST_S2;
            end
            ST_S2: begin
                en_s2       = 1'b1;
                w_state_nxt = ST_S3;
            end
            ST_S3: begin
                en_s3       = 1'b1;
                sym_done    = 1'b1;
                w_state_nxt = w_below ? ST_REFILL : ST_IDLE;
            end
            ST_REFILL: begin
                byte_ready = 1'b1;
                if (w_load && !w_below) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    // Counts bytes loaded during INIT
    always_ff @(posedge clk or negedge reset_ctrl) begin
        if (!reset_ctrl) begin
            r_init_cnt <= '0;
        end else if (r_state == ST_RST) begin
            r_init_cnt <= '0;
        end else if ((r_state == ST_INIT) && w_load) begin
            r_init_cnt <= r_init_cnt + INIT_CNT_W'(1);
        end
    end

`ifdef ARITH_DEC_STALL_CNT_EN
    // Counts loading cycles starved of both a byte and end-of-stream
    always_ff @(posedge clk or negedge reset_ctrl) begin
        if (!reset_ctrl) begin
            stall_cnt <= '0;
        end else if (w_loading && !byte_valid && !stream_end && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
